// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the stopwatch 7-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Scan position; also the only state machine in the display path.
    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    // Active-low one-hot anode select for a scan position.
    function automatic logic [NUM_DIGITS-1:0] anode_of(
        input digit_idx_t i_idx
    );
        logic [NUM_DIGITS-1:0] w_one;
        w_one = NUM_DIGITS'(1);
        return ~(w_one << i_idx);
    endfunction

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not BCD and render as a single dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pattern lookup; anything outside 0..9 shows a dash.
    always_comb begin
        o_seg = SEG_DASH;
        unique case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit common-anode multiplexed display driver.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]           r_pcnt;
    digit_idx_t              r_idx;
    logic                    r_en_d;
    logic [15:0]             r_snap_d;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_tick;

    logic                    w_term;
    logic                    w_wrap;
    logic                    w_first;
    logic                    w_snap;
    logic [3:0]              w_nib;
    logic                    w_dp_bit;
    logic [6:0]              w_dec;
    logic                    w_hide;

    assign w_term = enable && (r_pcnt == P_LAST);
    assign w_wrap = w_term && (r_idx == D3);

    // A scan that starts (or restarts) exactly at the frame origin must
    // snapshot there; in steady state the wrap edge already did it.
    assign w_first = enable && !r_en_d
                   && (r_idx == D0)
                   && (r_pcnt == '0);

    assign w_snap = w_wrap || w_first;

    // Select the snapshot nibble and dp request for the lit digit.
    always_comb begin
        w_nib = r_snap_d[3:0];
        unique case (r_idx)
            D0: w_nib = r_snap_d[3:0];
            D1: w_nib = r_snap_d[7:4];
            D2: w_nib = r_snap_d[11:8];
            D3: w_nib = r_snap_d[15:12];
        endcase
    end

    assign w_dp_bit = r_snap_dp[r_idx];

    bcd_to_seg7 u_dec (
        .i_bcd (w_nib),
        .o_seg (w_dec)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;

    // A digit is blank while it and all higher digits are plain zeros.
    always_comb begin
        w_blank    = '0;
        w_blank[3] = (r_snap_d[15:12] == 4'd0) && !r_snap_dp[3];
        w_blank[2] = w_blank[3]
                   && (r_snap_d[11:8] == 4'd0) && !r_snap_dp[2];
        w_blank[1] = w_blank[2]
                   && (r_snap_d[7:4] == 4'd0) && !r_snap_dp[1];
        w_blank[0] = 1'b0;
    end

    assign w_hide = w_blank[r_idx];
`else
    assign w_hide = 1'b0;
`endif

    // Prescaler and digit-index scan; both freeze while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
            r_idx  <= D0;
        end else if (w_term) begin
            r_pcnt <= '0;
            unique case (r_idx)
                D0: r_idx <= D1;
                D1: r_idx <= D2;
                D2: r_idx <= D3;
                D3: r_idx <= D0;
            endcase
        end else if (enable) begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Remember whether the previous edge was scanning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= enable;
        end
    end

    // Frame snapshot so a counter update never tears a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_d  <= '0;
            r_snap_dp <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_snap;
            if (w_snap) begin
                r_snap_d  <= digits;
                r_snap_dp <= dp_mask;
            end
        end
    end

    // Registered display drive, one cycle behind the scan index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (enable) begin
            r_an  <= anode_of(r_idx);
            r_seg <= w_hide ? SEG_BLANK : w_dec;
            r_dp  <= w_hide ? 1'b1 : ~w_dp_bit;
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan, REFRESH_DIV=4.
// Expected values are hand-computed per scan step.
module tb_seg7_scan;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seg7_scan #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // digit index 0..3 -> expected pattern
    logic [6:0] exp_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [6:0] exp_5    [4] = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_5dp  [4] = '{7'h12, 7'h40, 7'h40, 7'h7F};
`else
    logic [6:0] exp_5    [4] = '{7'h12, 7'h40, 7'h40, 7'h40};
    logic [6:0] exp_5dp  [4] = '{7'h12, 7'h40, 7'h40, 7'h40};
`endif

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] an_exp(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    initial begin
        int d;
        clk     = 1'b0;
        reset   = 1'b0;
        enable  = 1'b0;
        digits  = 16'h0000;
        dp_mask = 4'b0000;
        #1 reset = 1'b1;
        step(3);
        chk("rst_an",   16'(an),         16'hF);
        chk("rst_seg",  16'(seg),        16'h7F);
        chk("rst_dp",   16'(dp),         16'h1);
        chk("rst_tick", 16'(frame_tick), 16'h0);

        // decode: 1234 with dp on digit 2, two full frames
        digits  = 16'h1234;
        dp_mask = 4'b0100;
        enable  = 1'b1;
        reset   = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step(1);
            d = ((k - 1) / 4) % 4;
            chk("dec_an", 16'(an), 16'(an_exp(d)));
            chk("dec_seg", 16'(seg),
                16'((k == 1) ? 7'h40 : exp_1234[d]));
            chk("dec_dp", 16'(dp), 16'((d == 2) ? 1'b0 : 1'b1));
            chk("dec_tick", 16'(frame_tick),
                16'((k == 1 || k == 16 || k == 32) ? 1'b1 : 1'b0));
        end

        // tearing: 0000 snapped, then 9999 arrives while D1 is lit
        digits = 16'h0000;
        step(16);
        chk("tear_snap0", 16'(frame_tick), 16'h1);
        step(6);
        chk("tear_d1_an", 16'(an), 16'hD);
        digits = 16'h9999;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("tear_hold", 16'(seg), 16'h40);
        end
        chk("tear_tick", 16'(frame_tick), 16'h1);
        step(1);
        chk("tear_new_seg", 16'(seg), 16'h10);
        chk("tear_new_an",  16'(an),  16'hE);
        chk("tear_tick0",   16'(frame_tick), 16'h0);

        // invalid BCD nibbles render as dash
        digits = 16'hFA00;
        step(15);
        chk("inv_snap", 16'(frame_tick), 16'h1);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            d = (k - 1) / 4;
            chk("inv_an",  16'(an),  16'(an_exp(d)));
            chk("inv_seg", 16'(seg), 16'((d < 2) ? 7'h40 : 7'h3F));
        end
        chk("inv_tick", 16'(frame_tick), 16'h1);

        // enable drop while D2 lit with pcnt=1
        step(9);
        chk("en_pre_an", 16'(an), 16'hB);
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("dark_an",   16'(an),         16'hF);
            chk("dark_seg",  16'(seg),        16'h7F);
            chk("dark_dp",   16'(dp),         16'h1);
            chk("dark_tick", 16'(frame_tick), 16'h0);
        end
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("resume_an",   16'(an),         16'hB);
            chk("resume_seg",  16'(seg),        16'h3F);
            chk("resume_tick", 16'(frame_tick), 16'h0);
        end
        step(1);
        chk("resume_d3", 16'(an), 16'h7);

        // asynchronous reset mid-frame, then restart at D0
        #2 reset = 1'b1;
        #1;
        chk("arst_an",   16'(an),         16'hF);
        chk("arst_seg",  16'(seg),        16'h7F);
        chk("arst_dp",   16'(dp),         16'h1);
        chk("arst_tick", 16'(frame_tick), 16'h0);
        digits  = 16'h0005;
        dp_mask = 4'b0000;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            d = (k - 1) / 4;
            chk("lz_an", 16'(an), 16'(an_exp(d)));
            chk("lz_seg", 16'(seg),
                16'((k == 1) ? 7'h40 : exp_5[d]));
            chk("lz_dp", 16'(dp), 16'h1);
            chk("lz_tick", 16'(frame_tick),
                16'((k == 1 || k == 16) ? 1'b1 : 1'b0));
        end

        // dp on digit 2 stops blanking from there down
        dp_mask = 4'b0100;
        step(16);
        chk("lzdp_snap", 16'(frame_tick), 16'h1);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            d = (k - 1) / 4;
            chk("lzdp_an",  16'(an),  16'(an_exp(d)));
            chk("lzdp_seg", 16'(seg), 16'(exp_5dp[d]));
            chk("lzdp_dp",  16'(dp),  16'((d == 2) ? 1'b0 : 1'b1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed 7-segment display driver for the stopwatch. It sits directly downstream of the BCD digit counters: the hundredths, tenths, seconds and tens-of-seconds digit outputs are concatenated into one 16-bit bus. The block shows them on a 4-digit common-anode display by cycling one digit at a time at a refresh rate divided down from `clk`. Digits are snapshotted once per frame so a counter update never tears a displayed frame.

## Interface
- `REFRESH_DIV`, default 50000: `clk` cycles each digit stays lit. Legal range ≥ 2.
- `clk` (input, 1): system clock. All state advances on the rising edge.
- `reset` (input, 1): asynchronous, active-high reset.
- `enable` (input, 1): synchronous. While low, the display is dark and the scan is frozen.
- `digits` (input, 16): four BCD nibbles. `[3:0]` is the rightmost digit (digit 0, hundredths); `[15:12]` is digit 3.
- `dp_mask` (input, 4): decimal point request per digit. Bit i maps to digit i.
- `an` (output, 4): anode selects, active-low, one-hot-low while enabled.
- `seg` (output, 7): segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` (output, 1): decimal point, active-low.
- `frame_tick` (output, 1): one-cycle pulse on each frame wrap.

## Operation
- **Prescaler `pcnt`**
  - Counts 0..REFRESH_DIV−1 while `enable`=1.
  - `term` = (`pcnt` == REFRESH_DIV−1) and `enable`.
  - On `term`, `pcnt` returns to 0 and digit index `idx` advances 0→1→2→3→0.
- **Snapshot**
  - On the `term` edge where `idx` wraps 3→0, `digits` and `dp_mask` load into the snapshot registers `snap_d` and `snap_dp`, and `frame_tick` pulses for that cycle.
  - The first snapshot after reset is taken on the first `clk` edge with `enable`=1 and `idx`=0 and `pcnt`=0. That edge also pulses `frame_tick`.
- **Decode**
  - BCD 0–9 use the standard patterns.
  - Nibbles 10–15 show a dash (segment g only, `seg`=7'b0111111).
- **Output register**
  - Each cycle with `enable`=1: `an` drives `idx` active-low, `seg` drives decode(`snap_d[idx]`), `dp` drives ~`snap_dp[idx]`.
  - With `enable`=0: `an`=4'b1111, `seg`=7'h7F, `dp`=1. `pcnt` and `idx` hold.
- **Reset values**
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_tick`=0.
  - `pcnt`=0, `idx`=0, `snap_d`=0, `snap_dp`=0.
- **State sequence:** the `idx` sequence is the only state machine: D0→D1→D2→D3→D0. There are no other states and no illegal encodings (`idx` is 2 bits).

## Timing
- `an`/`seg`/`dp` lag `idx` by exactly one `clk` cycle: registered output, no combinational path from `digits`.
- After the snapshot edge, the new value of digit 0 appears on `seg` one cycle later.
- In steady state each digit is lit for exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles.
- `digits` changing mid-frame has no effect until the next wrap. Changing on the wrap edge itself: the value present on that edge is captured.
- `enable` falling: outputs go dark on the next edge and the scan freezes at the current `pcnt`/`idx`. `enable` rising: the scan resumes from the frozen position with no snapshot, unless that position is `idx`=0, `pcnt`=0.
- `reset` asserted mid-frame: all registers take their reset values immediately (asynchronous). After release, the scan restarts at D0.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN`
  - **Defined:** digits 3, 2 and 1 are blanked (`seg`=7'h7F, `dp`=1, anode still driven) while they and every higher digit are zero with their `dp` bit clear. A set `dp` bit or a nonzero nibble stops blanking for that digit and all lower digits. Digit 0 is never blanked. Blanking uses snapshot values.
  - **Undefined:** all four digits are always shown, zeros included.

## Structure
- **Package `seg7_pkg`:** segment pattern constants for 0–9, `SEG_BLANK` (7'h7F), `SEG_DASH` (7'b0111111), `NUM_DIGITS`=4, digit-index type (2 bits).
- **Sub-module `bcd_to_seg7`:** purely combinational, 4-bit in, 7-bit active-low out, instantiated once on the muxed snapshot nibble.
- The prescaler, index counter, snapshot, blanking logic and output registers stay in `seg7_scan`.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset:** assert `reset` mid-scan → `an`=1111, `seg`=7F, `dp`=1 immediately. After release with `enable`=1, `an` sequence is 1110 for 4 cycles, 1101, 1011, 0111, then repeats.
- **Decode:** `digits`=16'h1234, `dp_mask`=4'b0100 → digit 0 `seg`=0011001 (4), digit 1 `seg`=0110000 (3), digit 2 `seg`=0100100 (2) with `dp`=0, digit 3 `seg`=1111001 (1). `frame_tick` pulses every 16 cycles.
- **Tearing:** change `digits` from 16'h0000 to 16'h9999 while D1 is lit → D1–D3 still show 0 for that frame. 9 appears starting with D0 of the next frame, after `frame_tick`.
- **Invalid BCD:** `digits`=16'hFA00 → D3 and D2 show dash (0111111), D1 and D0 show 0.
- **Enable:** drop `enable` for 10 cycles while D2 is lit with `pcnt`=1 → dark for 10 cycles. After re-enable, D2 is lit for the remaining 3 cycles, then D3.
- **Leading-zero blanking** (`SEG7_LEADING_ZERO_BLANK_EN` defined): `digits`=16'h0005 → D3–D1 blank, D0 shows 5. `digits`=16'h0005 with `dp_mask`=4'b0100 → D3 blank; D2 shows 0 with its decimal point lit; D1 shows 0; D0 shows 5.
